// File: rtl/mem_stall_ctrl_if.sv
// mem_stall_ctrl_if - valid/ready request + response bus between the MEM-stage
// controller and the data memory.
//   master : controller side (drives request, receives ready/response)
//   slave  : memory side
// Signals:
//   MEM_ReqValid  request valid          MEM_ReqReady  memory accepts request
//   MEM_ReqWrite  1=store, 0=load        MEM_Addr      request address
//   MEM_WData     store data             MEM_RespValid read data valid / write ack
//   MEM_RData     read data
interface mem_stall_ctrl_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              MEM_ReqValid;
    logic              MEM_ReqReady;
    logic              MEM_ReqWrite;
    logic [ADDR_W-1:0] MEM_Addr;
    logic [DATA_W-1:0] MEM_WData;
    logic              MEM_RespValid;
    logic [DATA_W-1:0] MEM_RData;

    modport master (
        output MEM_ReqValid, MEM_ReqWrite, MEM_Addr, MEM_WData,
        input  MEM_ReqReady, MEM_RespValid, MEM_RData
    );

    modport slave (
        input  MEM_ReqValid, MEM_ReqWrite, MEM_Addr, MEM_WData,
        output MEM_ReqReady, MEM_RespValid, MEM_RData
    );
endinterface

// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl - multi-cycle data-memory responder for the MEM stage.
// Issues one memory request per EX/MEM load/store and freezes the upstream
// pipeline (Mem_Stall) until the access completes; the DONE cycle releases the
// stall for exactly one cycle so the pipeline advances.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   EXMEM_MemRead/MemWrite         access request from EX/MEM
//   EXMEM_Addr/EXMEM_WData         access address / store data
//   memIf (master)                 memory request/response bus
//   MEMWB_RData                    captured load data for MEM/WB
//   Mem_Stall                      pipeline freeze
//   Mem_Err                        one-cycle timeout pulse (0 unless timeout built)
//   Stall_Count                    saturating count of stalled cycles
// Build option: define MEM_TIMEOUT_EN to force completion after TIMEOUT
// WAIT cycles without a response.
module mem_stall_ctrl #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              EXMEM_MemRead,
    input  logic              EXMEM_MemWrite,
    input  logic [ADDR_W-1:0] EXMEM_Addr,
    input  logic [DATA_W-1:0] EXMEM_WData,
    mem_stall_ctrl_if.master  memIf,
    output logic [DATA_W-1:0] MEMWB_RData,
    output logic              Mem_Stall,
    output logic              Mem_Err,
    output logic [31:0]       Stall_Count
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t state, stateNext;
    logic   accessReq;
    logic   capture;     // response accepted this cycle

    assign accessReq = EXMEM_MemRead | EXMEM_MemWrite;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;
    logic [CNT_W-1:0] waitCnt;
    logic             timedOut;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        capture   = 1'b0;
`ifdef MEM_TIMEOUT_EN
        timedOut  = 1'b0;
`endif
        case (state)
            IDLE: if (accessReq) stateNext = REQ;
            REQ: begin
                if (memIf.MEM_ReqReady) begin
                    if (memIf.MEM_RespValid) begin
                        stateNext = DONE;
                        capture   = 1'b1;
                    end else begin
                        stateNext = WAIT;
                    end
                end
            end
            WAIT: begin
                // A response on the final timeout cycle wins over the timeout.
                if (memIf.MEM_RespValid) begin
                    stateNext = DONE;
                    capture   = 1'b1;
                end
`ifdef MEM_TIMEOUT_EN
                else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
                    stateNext = DONE;
                    timedOut  = 1'b1;
                end
`endif
            end
            // The EX/MEM op is still visible here but is already serviced.
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Stall starts combinationally in the IDLE cycle that sees the request.
    assign Mem_Stall = rst_n & (((state == IDLE) & accessReq) | (state == REQ) | (state == WAIT));
    assign memIf.MEM_ReqValid = (state == REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memIf.MEM_Addr     <= '0;
            memIf.MEM_WData    <= '0;
            memIf.MEM_ReqWrite <= 1'b0;
            MEMWB_RData        <= '0;
            Stall_Count        <= '0;
        end else begin
            if ((state == IDLE) && accessReq) begin
                memIf.MEM_Addr     <= EXMEM_Addr;
                memIf.MEM_WData    <= EXMEM_WData;
                memIf.MEM_ReqWrite <= EXMEM_MemWrite & ~EXMEM_MemRead;  // read wins
            end
            if (capture && !memIf.MEM_ReqWrite)
                MEMWB_RData <= memIf.MEM_RData;
`ifdef MEM_TIMEOUT_EN
            // A timed-out load returns zero; stores never touch MEMWB_RData.
            else if (timedOut && !memIf.MEM_ReqWrite)
                MEMWB_RData <= '0;
`endif
            if (Mem_Stall && (Stall_Count != 32'hFFFF_FFFF))
                Stall_Count <= Stall_Count + 32'd1;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Counter is held at zero outside WAIT, so it starts from zero on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCnt <= '0;
            Mem_Err <= 1'b0;
        end else begin
            waitCnt <= (state == WAIT) ? waitCnt + 1'b1 : '0;
            Mem_Err <= timedOut;  // high during the DONE cycle
        end
    end
`else
    logic [31:0] unusedTimeout;
    assign unusedTimeout = 32'(TIMEOUT);
    assign Mem_Err       = 1'b0;
`endif

endmodule
